text_console: RTL and testbench
===============================

TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 SHALL have parameter COLS, default 80, characters per row.
REQ-002 SHALL have parameter ROWS, default 30, character rows.
REQ-003 SHALL have parameter CHAR_W, default 8, glyph width in pixels, power of two.
REQ-004 SHALL have parameter CHAR_H, default 16, glyph height in pixels, power of two.
REQ-005 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per cursor blink half-period.
REQ-006 SHALL have ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- ascii_in  in  8  character code.
- in_valid  in  1  ascii_in valid.
- in_ready  out  1  block can accept ascii_in this cycle.
- kbsig  in  16  key levels: bit 8 up, bit 7 down, bit 6 left, bit 5 right; other bits ignored.
- addra  in  32  linear pixel address, row-major, H_RES = COLS*CHAR_W pixels per line.
- char_out  out  8  character code at addra's cell.
- gx  out  3  pixel column inside glyph (addra % CHAR_W).
- gy  out  4  pixel row inside glyph ((addra / H_RES) % CHAR_H).
- cursor_on  out  1  addra's cell is the cursor cell and blink phase is visible.
- cur_row  out  log2(ROWS)  cursor row.
- cur_col  out  log2(COLS)  cursor column.
- busy  out  1  CLEAR or SCROLL in progress.

Function
REQ-007 SHALL hold a COLS*ROWS x 8-bit cell buffer, cell index = row*COLS + col.
REQ-008 SHALL implement states IDLE, CLEAR and SCROLL.
REQ-009 SHALL drive in_ready=1 only in IDLE; transfer occurs when in_valid && in_ready.
REQ-010 Printable 0x20-0x7E SHALL write to the cursor cell and advance col; at col COLS-1, col becomes 0 and row+1; at row ROWS-1, SCROLL is entered.
REQ-011 0x0D or 0x0A SHALL set col to 0 and row+1; at row ROWS-1, SCROLL is entered.
REQ-012 0x08 SHALL move the cursor back one cell and write 0x20 there.
- Col 0 with row>0: moves to (row-1, COLS-1).
- At (0,0): no-op.
REQ-013 All other codes SHALL be accepted and ignored.
REQ-014 Each arrow bit SHALL act once per rising edge (registered previous kbsig).
- Moves are processed only in IDLE in cycles with no ascii transfer; edges arriving otherwise are dropped.
- Movement clamps at borders, no wrap.
- Simultaneous edges priority: up, down, left, right; one move per cycle.
REQ-015 SCROLL SHALL proceed in two phases, then return to IDLE with cursor at (ROWS-1, 0); total COLS*ROWS cycles.
- Copy phase: copy cell i+COLS to cell i for i = 0 .. COLS*(ROWS-1)-1, one cell per cycle.
- Fill phase: write 0x20 to the last row, one cell per cycle.
REQ-016 CLEAR SHALL write 0x20 to all cells, one per cycle, then enter IDLE; lasts COLS*ROWS cycles.
REQ-017 busy SHALL be 1 exactly in CLEAR and SCROLL.
REQ-018 Display read SHALL be registered with 1-cycle latency: char_out, gx, gy and cursor_on correspond to addra of the previous cycle.
REQ-019 Display cell SHALL be (addra / (H_RES*CHAR_H))*COLS + (addra % H_RES)/CHAR_W.
REQ-020 Display read SHALL run every cycle in every state.
- Content mid-SCROLL may be partially updated.
- addra >= H_RES*CHAR_H*ROWS yields char_out 0x20 and cursor_on 0.
REQ-021 Blink counter SHALL count 0 .. BLINK_DIV-1 and toggle the blink phase on wrap.
- Any cursor move or ascii transfer restarts the counter and sets phase visible.

Reset
REQ-022 On rst=1, the block SHALL apply the following.
- Enter CLEAR and restart its cell counter at 0.
- Cursor (0,0), blink phase visible, blink counter 0.
- in_ready 0, busy 1.
- char_out 0x20, gx 0, gy 0, cursor_on 0.
REQ-023 rst asserted mid-SCROLL or mid-CLEAR SHALL abort the operation and restart CLEAR from cell 0.

Verification
REQ-024 Reset: pulse rst, wait COLS*ROWS cycles -> busy 0, in_ready 1, every cell reads 0x20, cursor (0,0).
REQ-025 Type 'H','i' -> cells 0,1 = 0x48,0x69, cursor (0,2); addra=8 gives char_out 0x69, gx 0 one cycle later.
REQ-026 Cursor (0,79), type 'A' -> cursor (1,0).
REQ-027 Cursor (0,0), send 0x08 -> no change.
REQ-028 Cursor (29,5), send 0x0D -> busy 1 for 2400 cycles.
- During scroll: in_ready 0 and in_valid held high is not consumed.
- Afterwards: former row 1 appears in row 0, row 29 all 0x20, cursor (29,0).
REQ-029 Hold kbsig[5]=1 for 10 cycles -> cursor col +1 exactly once.
- Assert rst during a scroll -> CLEAR restarts from cell 0 and the whole buffer reads 0x20.

Source files
------------

// File: rtl/text_console.sv
// Character-cell text console: cursor-driven cell buffer with clear/scroll sequencer and pixel-addressed glyph lookup.
// Latency: display outputs (char_out/gx/gy/cursor_on) lag addra by one cycle; clear and scroll each take COLS*ROWS cycles.
// Backpressure: in_ready is high only in IDLE; arrow-key edges not serviceable in that cycle are dropped.
module text_console #(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int CHAR_W    = 8,
    parameter int CHAR_H    = 16,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  ascii_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [15:0]                 kbsig,
    input  logic [31:0]                 addra,
    output logic [7:0]                  char_out,
    output logic [$clog2(CHAR_W)-1:0]   gx,
    output logic [$clog2(CHAR_H)-1:0]   gy,
    output logic                        cursor_on,
    output logic [$clog2(ROWS)-1:0]     cur_row,
    output logic [$clog2(COLS)-1:0]     cur_col,
    output logic                        busy
);

    localparam int NCELL = COLS * ROWS;
    localparam int CW    = $clog2(NCELL);
    localparam int RW    = $clog2(ROWS);
    localparam int CLW   = $clog2(COLS);
    localparam int GXW   = $clog2(CHAR_W);
    localparam int GYW   = $clog2(CHAR_H);
    localparam int H_RES = COLS * CHAR_W;
    localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCROLL} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   ctr;
    logic [7:0]      mem [NCELL];

    logic [3:0]      kb_prev;
    logic [3:0]      kb_edge;          // {up, down, left, right}
    logic            xfer;
    logic            printable, is_nl, is_bs;
    logic            op_done, copy_phase, scroll_go;
    logic [CW-1:0]   cur_idx, src_idx;

    logic [RW-1:0]   row_nxt;
    logic [CLW-1:0]  col_nxt;
    logic            blink_restart;
    logic            wr_en;
    logic [CW-1:0]   wr_idx;
    logic [7:0]      wr_dat;

    logic [BW-1:0]   blink_cnt;
    logic            blink_vis;

    logic [31:0]     pix_line, disp_row32, disp_col32, disp_idx32;
    logic            in_range;
    logic [CW-1:0]   disp_idx;

    assign xfer       = in_valid && in_ready;
    assign printable  = (ascii_in >= 8'h20) && (ascii_in <= 8'h7E);
    assign is_nl      = (ascii_in == 8'h0D) || (ascii_in == 8'h0A);
    assign is_bs      = (ascii_in == 8'h08);
    assign kb_edge    = kbsig[8:5] & ~kb_prev;
    assign op_done    = (ctr == CW'(NCELL - 1));
    assign copy_phase = (ctr < CW'(NCELL - COLS));
    // Source row is one below the destination during the copy phase.
    assign src_idx    = copy_phase ? (ctr + CW'(COLS)) : ctr;
    assign cur_idx    = CW'(cur_row) * CW'(COLS) + CW'(cur_col);
    // A newline or a wrap on the bottom row pushes everything up one line.
    assign scroll_go  = xfer && (cur_row == RW'(ROWS - 1)) &&
                        (is_nl || (printable && (cur_col == CLW'(COLS - 1))));

    // State register: reset always restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) state <= S_CLEAR;
        else     state <= state_nxt;
    end

    // Next-state: scroll on bottom-row overflow, sweeps return to IDLE on their last cell.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (scroll_go) state_nxt = S_SCROLL;
            S_CLEAR:  if (op_done)   state_nxt = S_IDLE;
            S_SCROLL: if (op_done)   state_nxt = S_IDLE;
            default:                 state_nxt = S_CLEAR;
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        in_ready = (state == S_IDLE);
        busy     = (state != S_IDLE);
    end

    // Cursor update and the single cell-buffer write for this cycle.
    always_comb begin
        row_nxt       = cur_row;
        col_nxt       = cur_col;
        blink_restart = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = ctr;
        wr_dat        = 8'h20;
        case (state)
            S_CLEAR: begin
                wr_en = 1'b1;
            end
            S_SCROLL: begin
                wr_en  = 1'b1;
                wr_dat = copy_phase ? mem[src_idx] : 8'h20;
                if (op_done) begin
                    row_nxt = RW'(ROWS - 1);
                    col_nxt = '0;
                end
            end
            default: begin
                if (xfer) begin
                    blink_restart = 1'b1;
                    if (printable) begin
                        wr_en  = 1'b1;
                        wr_idx = cur_idx;
                        wr_dat = ascii_in;
                        if (cur_col == CLW'(COLS - 1)) begin
                            col_nxt = '0;
                            if (cur_row != RW'(ROWS - 1)) row_nxt = cur_row + RW'(1);
                        end else begin
                            col_nxt = cur_col + CLW'(1);
                        end
                    end else if (is_nl) begin
                        col_nxt = '0;
                        if (cur_row != RW'(ROWS - 1)) row_nxt = cur_row + RW'(1);
                    end else if (is_bs) begin
                        // Previous cell is always cur_idx-1, including wrap to the prior row's end.
                        if (cur_col != '0) begin
                            col_nxt = cur_col - CLW'(1);
                            wr_en   = 1'b1;
                            wr_idx  = cur_idx - CW'(1);
                        end else if (cur_row != '0) begin
                            row_nxt = cur_row - RW'(1);
                            col_nxt = CLW'(COLS - 1);
                            wr_en   = 1'b1;
                            wr_idx  = cur_idx - CW'(1);
                        end
                    end
                end else if (kb_edge[3]) begin
                    if (cur_row != '0) begin
                        row_nxt       = cur_row - RW'(1);
                        blink_restart = 1'b1;
                    end
                end else if (kb_edge[2]) begin
                    if (cur_row != RW'(ROWS - 1)) begin
                        row_nxt       = cur_row + RW'(1);
                        blink_restart = 1'b1;
                    end
                end else if (kb_edge[1]) begin
                    if (cur_col != '0) begin
                        col_nxt       = cur_col - CLW'(1);
                        blink_restart = 1'b1;
                    end
                end else if (kb_edge[0]) begin
                    if (cur_col != CLW'(COLS - 1)) begin
                        col_nxt       = cur_col + CLW'(1);
                        blink_restart = 1'b1;
                    end
                end
            end
        endcase
    end

    // Cell buffer write port; suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_idx] <= wr_dat;
    end

    // Previous key levels for rising-edge detection; edges outside IDLE are consumed and lost.
    always_ff @(posedge clk) begin
        kb_prev <= kbsig[8:5];
    end

    // Sweep counter and cursor position.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr     <= '0;
            cur_row <= '0;
            cur_col <= '0;
        end else begin
            ctr     <= (state == S_IDLE || op_done) ? '0 : ctr + CW'(1);
            cur_row <= row_nxt;
            cur_col <= col_nxt;
        end
    end

    // Cursor blink: free-running half-period counter, restarted visible on any activity.
    always_ff @(posedge clk) begin
        if (rst || blink_restart) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_vis <= ~blink_vis;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Pixel address to cell/glyph coordinates; out-of-screen addresses read as blank.
    always_comb begin
        pix_line   = addra / 32'(H_RES);
        disp_row32 = addra / 32'(H_RES * CHAR_H);
        disp_col32 = (addra % 32'(H_RES)) / 32'(CHAR_W);
        in_range   = (addra < 32'(H_RES * CHAR_H * ROWS));
        disp_idx32 = disp_row32 * 32'(COLS) + disp_col32;
        disp_idx   = in_range ? disp_idx32[CW-1:0] : '0;
    end

    // Registered display read, active in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_out  <= 8'h20;
            gx        <= '0;
            gy        <= '0;
            cursor_on <= 1'b0;
        end else begin
            char_out  <= in_range ? mem[disp_idx] : 8'h20;
            gx        <= addra[GXW-1:0];
            gy        <= pix_line[GYW-1:0];
            cursor_on <= in_range && blink_vis &&
                         (disp_row32 == 32'(cur_row)) && (disp_col32 == 32'(cur_col));
        end
    end

    logic unused_bits;
    assign unused_bits = ^{kbsig[15:9], kbsig[4:0], pix_line[31:GYW], disp_idx32[31:CW]};

endmodule

// File: tb/tb_text_console.sv
module tb_text_console;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;
    localparam int BLINK  = 50;
    localparam int NCELL  = COLS * ROWS;
    localparam int H_RES  = COLS * CHAR_W;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ascii_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] kbsig;
    logic [31:0] addra;
    logic [7:0]  char_out;
    logic [2:0]  gx;
    logic [3:0]  gy;
    logic        cursor_on;
    logic [4:0]  cur_row;
    logic [6:0]  cur_col;
    logic        busy;

    int checks = 0;
    int errors = 0;

    text_console #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .BLINK_DIV(BLINK)
    ) dut (
        .clk(clk), .rst(rst), .ascii_in(ascii_in), .in_valid(in_valid), .in_ready(in_ready),
        .kbsig(kbsig), .addra(addra), .char_out(char_out), .gx(gx), .gy(gy),
        .cursor_on(cursor_on), .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        ascii_in = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic press(input int b);
        kbsig[b] = 1'b1;
        tick();
        kbsig[b] = 1'b0;
        tick();
    endtask

    task automatic chk_cur(input string tag, input int r, input int c);
        chk({tag, "_row"}, 32'(cur_row), 32'(r));
        chk({tag, "_col"}, 32'(cur_col), 32'(c));
    endtask

    task automatic chk_cell(input string tag, input int r, input int c, input logic [7:0] exp);
        addra = 32'(r * H_RES * CHAR_H + c * CHAR_W);
        tick();
        chk(tag, 32'(char_out), 32'(exp));
    endtask

    task automatic chk_blank_row(input string tag, input int r);
        for (int c = 0; c < COLS; c++) chk_cell(tag, r, c, 8'h20);
    endtask

    // Counts cycles with busy high (bounded) and flags any in_ready during that window.
    task automatic wait_busy(input string tag, input int exp_n);
        int   n;
        logic rdy_seen;
        n = 0;
        rdy_seen = 1'b0;
        while (busy === 1'b1 && n < 4000) begin
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
        chk({tag, "_in_ready_while_busy"}, 32'(rdy_seen), 32'd0);
        chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        ascii_in = 8'h00;
        in_valid = 1'b0;
        kbsig    = 16'h0000;
        addra    = 32'd0;
        tick();
        tick();

        // Reset state
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_char_out", 32'(char_out), 32'h20);
        chk("rst_gx", 32'(gx), 32'd0);
        chk("rst_gy", 32'(gy), 32'd0);
        chk("rst_cursor_on", 32'(cursor_on), 32'd0);
        chk_cur("rst_cur", 0, 0);
        rst = 1'b0;
        wait_busy("clear", NCELL);
        chk_cur("post_clear_cur", 0, 0);
        for (int r = 0; r < ROWS; r++) chk_blank_row("clear_cell", r);

        // Typing 'H','i'
        send(8'h48);
        send(8'h69);
        chk_cur("hi_cur", 0, 2);
        chk_cell("cur_cell_blank", 0, 2, 8'h20);
        chk("cursor_on_at_cursor", 32'(cursor_on), 32'd1);
        addra = 32'd8;
        tick();
        chk("addr8_char", 32'(char_out), 32'h69);
        chk("addr8_gx", 32'(gx), 32'd0);
        chk("addr8_cursor_on", 32'(cursor_on), 32'd0);
        chk_cell("cell0_H", 0, 0, 8'h48);
        addra = 32'(3 * H_RES + 1 * CHAR_W + 5);
        tick();
        chk("glyph_char", 32'(char_out), 32'h69);
        chk("glyph_gx", 32'(gx), 32'd5);
        chk("glyph_gy", 32'(gy), 32'd3);

        // Newline, row 1 text, backspace mid-row
        send(8'h0D);
        chk_cur("cr_cur", 1, 0);
        send(8'h41);
        send(8'h42);
        send(8'h43);
        chk_cur("abc_cur", 1, 3);
        send(8'h08);
        chk_cur("bs_cur", 1, 2);
        chk_cell("bs_erased", 1, 2, 8'h20);
        chk_cell("bs_keep", 1, 1, 8'h42);

        // Line wrap from the last column
        press(8);
        chk_cur("up_cur", 0, 2);
        for (int i = 0; i < 77; i++) press(5);
        chk_cur("right77_cur", 0, 79);
        send(8'h41);
        chk_cur("wrap_cur", 1, 0);
        chk_cell("wrap_cell", 0, 79, 8'h41);

        // Backspace across a row boundary
        send(8'h08);
        chk_cur("bs_wrap_cur", 0, 79);
        chk_cell("bs_wrap_cell", 0, 79, 8'h20);

        // Border clamps
        press(8);
        chk_cur("clamp_up", 0, 79);
        press(5);
        chk_cur("clamp_right", 0, 79);

        // Backspace at origin is a no-op
        send(8'h0A);
        press(8);
        chk_cur("origin_cur", 0, 0);
        send(8'h08);
        chk_cur("bs_origin_cur", 0, 0);
        chk_cell("bs_origin_cell", 0, 0, 8'h48);

        // Held key moves once
        kbsig[5] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        kbsig[5] = 1'b0;
        tick();
        chk_cur("hold_right", 0, 1);

        // Non-printable control code ignored
        send(8'h07);
        chk_cur("bel_cur", 0, 1);
        chk_cell("bel_cell", 0, 1, 8'h69);

        // Simultaneous down+right: down wins
        kbsig[7] = 1'b1;
        kbsig[5] = 1'b1;
        tick();
        kbsig[7] = 1'b0;
        kbsig[5] = 1'b0;
        tick();
        chk_cur("prio_cur", 1, 1);

        // Blink phase goes dark after one half-period
        for (int i = 0; i < 58; i++) tick();
        chk_cell("blink_cell", 1, 1, 8'h42);
        chk("blink_off", 32'(cursor_on), 32'd0);

        // Move to bottom row, write marker, then scroll
        for (int i = 0; i < 28; i++) press(7);
        chk_cur("bottom_cur", 29, 1);
        send(8'h51);
        send(8'h52);
        send(8'h53);
        send(8'h54);
        chk_cur("qrst_cur", 29, 5);
        ascii_in = 8'h0D;
        in_valid = 1'b1;
        tick();
        ascii_in = 8'h58;
        wait_busy("scroll", NCELL);
        in_valid = 1'b0;
        chk_cur("scroll_cur", 29, 0);
        chk_cell("scroll_r0c0", 0, 0, 8'h41);
        chk_cell("scroll_r0c1", 0, 1, 8'h42);
        chk_cell("scroll_r0c2", 0, 2, 8'h20);
        chk_cell("scroll_r28c0", 28, 0, 8'h20);
        chk_cell("scroll_r28c1", 28, 1, 8'h51);
        chk_cell("scroll_r28c4", 28, 4, 8'h54);
        chk_cell("scroll_r28c5", 28, 5, 8'h20);
        chk_blank_row("scroll_r29", 29);

        // Out-of-screen addresses
        addra = 32'(H_RES * CHAR_H * ROWS);
        tick();
        chk("oob_char", 32'(char_out), 32'h20);
        chk("oob_cursor_on", 32'(cursor_on), 32'd0);

        // Reset in the middle of a scroll
        send(8'h0A);
        for (int i = 0; i < 100; i++) tick();
        chk("mid_scroll_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_char", 32'(char_out), 32'h20);
        chk_cur("mid_rst_cur", 0, 0);
        rst = 1'b0;
        wait_busy("reclear", NCELL);
        chk_cur("reclear_cur", 0, 0);
        for (int r = 0; r < ROWS; r++) chk_blank_row("reclear_cell", r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
